// File: rtl/ofdm_tx_frm_sched.sv
// ofdm_tx_frm_sched: frame scheduler at the output of the OFDM TX chain.
// Shares one Wishbone-style output port between the preamble source and the
// IFFT/CP data-symbol stream. Each frame is sent as the preamble, then NSYM
// data symbols, then an idle guard gap. A single registered output entry
// decouples the sink handshake from the source acknowledges.
module ofdm_tx_frm_sched #(
    parameter int PRE_LEN = 320,
    parameter int SYM_LEN = 80,
    parameter int GAP_LEN = 16,
    parameter int NSYM_W  = 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              START_I,
    input  logic [NSYM_W-1:0] NSYM_I,
    input  logic [31:0]       PRE_DAT_I,
    input  logic              PRE_WE_I,
    input  logic              PRE_STB_I,
    input  logic              PRE_CYC_I,
    output logic              PRE_ACK_O,
    input  logic [31:0]       SYM_DAT_I,
    input  logic              SYM_WE_I,
    input  logic              SYM_STB_I,
    input  logic              SYM_CYC_I,
    output logic              SYM_ACK_O,
    output logic [31:0]       DAT_O,
    output logic              WE_O,
    output logic              STB_O,
    output logic              CYC_O,
    input  logic              ACK_I,
    output logic              BUSY_O,
    output logic              FRM_DONE_O
);

    localparam int MAX_LEN = (PRE_LEN > SYM_LEN) ? PRE_LEN : SYM_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int GW      = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [CW-1:0]     PRE_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0]     SYM_LAST = CW'(SYM_LEN - 1);
    // GAP_LEN of 0 or 1 both leave after a single GAP cycle
    localparam logic [GW-1:0]     GAP_LAST = GW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam logic [NSYM_W-1:0] NSYM_ONE = NSYM_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SYM   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [NSYM_W-1:0] nsym_q, nsym_d;
    logic [CW-1:0]     smp_cnt_q, smp_cnt_d;
    logic [NSYM_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              last_done_q, last_done_d;
    logic [31:0]       dat_q, dat_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              frm_done_q, frm_done_d;

    logic              pre_req_s;
    logic              sym_req_s;
    logic              can_load_s;
    logic              pre_ack_s;
    logic              sym_ack_s;
    logic              load_s;
    logic              out_xfer_s;
    logic [31:0]       ld_dat_s;

    assign pre_req_s  = PRE_WE_I & PRE_STB_I & PRE_CYC_I;
    assign sym_req_s  = SYM_WE_I & SYM_STB_I & SYM_CYC_I;
    assign can_load_s = ~stb_q | ACK_I;
    assign load_s     = pre_ack_s | sym_ack_s;
    assign out_xfer_s = stb_q & stb_q & cyc_q & ACK_I;

    // Source acknowledge: only the source owning the current phase is acked
    always_comb begin
        pre_ack_s = 1'b0;
        sym_ack_s = 1'b0;
        case (state_q)
            ST_PRE:  pre_ack_s = pre_req_s & can_load_s & ~last_done_q;
            ST_SYM:  sym_ack_s = sym_req_s & can_load_s & ~last_done_q;
            default: begin
                pre_ack_s = 1'b0;
                sym_ack_s = 1'b0;
            end
        endcase
    end

    // Load-data mux: data stream in SYM, preamble otherwise
    always_comb begin
        ld_dat_s = PRE_DAT_I;
        if (state_q == ST_SYM) begin
            ld_dat_s = SYM_DAT_I;
        end else begin
            ld_dat_s = PRE_DAT_I;
        end
    end

    // Frame sequencer: next state, phase counters and frame-done pulse
    always_comb begin
        state_d     = state_q;
        nsym_d      = nsym_q;
        smp_cnt_d   = smp_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_done_d = last_done_q;
        frm_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START_I) begin
                    nsym_d      = NSYM_I;
                    smp_cnt_d   = '0;
                    sym_cnt_d   = '0;
                    last_done_d = 1'b0;
                    state_d     = ST_PRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (pre_ack_s) begin
                    if (smp_cnt_q == PRE_LAST) begin
                        smp_cnt_d = '0;
                        if (nsym_q == '0) begin
                            last_done_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end else begin
                            last_done_d = 1'b0;
                            state_d     = ST_SYM;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_PRE;
                end
            end
            ST_SYM: begin
                if (sym_ack_s) begin
                    if (smp_cnt_q == SYM_LAST) begin
                        smp_cnt_d = '0;
                        if (sym_cnt_q == (nsym_q - NSYM_ONE)) begin
                            last_done_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end else begin
                            sym_cnt_d = sym_cnt_q + NSYM_ONE;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_SYM;
                end
            end
            ST_DRAIN: begin
                // leave only once the sink has taken the last held sample
                if (!stb_q) begin
                    gap_cnt_d   = '0;
                    last_done_d = 1'b0;
                    state_d     = ST_GAP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = '0;
                    frm_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: single registered entry plus frame-level CYC envelope
    always_comb begin
        dat_d  = dat_q;
        stb_d  = stb_q;
        cyc_d  = cyc_q;
        busy_d = (state_d != ST_IDLE);
        if (load_s) begin
            dat_d = ld_dat_s;
            stb_d = 1'b1;
        end else if (out_xfer_s) begin
            stb_d = 1'b0;
        end else begin
            stb_d = stb_q;
        end
        if ((state_d == ST_GAP) || (state_d == ST_IDLE)) begin
            cyc_d = 1'b0;
        end else if (load_s) begin
            cyc_d = 1'b1;
        end else begin
            cyc_d = cyc_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q     <= ST_IDLE;
            nsym_q      <= '0;
            smp_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            last_done_q <= 1'b0;
            dat_q       <= 32'h0000_0000;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            frm_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nsym_q      <= nsym_d;
            smp_cnt_q   <= smp_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_done_q <= last_done_d;
            dat_q       <= dat_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            frm_done_q  <= frm_done_d;
        end
    end

    assign PRE_ACK_O  = pre_ack_s;
    assign SYM_ACK_O  = sym_ack_s;
    assign DAT_O      = dat_q;
    assign STB_O      = stb_q;
    assign WE_O       = stb_q;
    assign CYC_O      = cyc_q;
    assign BUSY_O     = busy_q;
    assign FRM_DONE_O = frm_done_q;

endmodule

// File: tb/tb_ofdm_tx_frm_sched.sv
// Testbench for ofdm_tx_frm_sched: randomized and directed frames, with a
// scoreboard of expected output samples built from the frame rules and a
// separate monitor that pops and compares on every output transfer.
module tb_ofdm_tx_frm_sched;

    localparam int PRE_LEN = 320;
    localparam int SYM_LEN = 80;
    localparam int GAP_LEN = 16;
    localparam int NSYM_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NSYM_W-1:0] nsym;
    logic [31:0]       pre_dat, sym_dat, dat_o;
    logic              pre_we, pre_stb, pre_cyc, pre_ack;
    logic              sym_we, sym_stb, sym_cyc, sym_ack;
    logic              we_o, stb_o, cyc_o, ack_i, busy, frm_done;

    always #5 clk = ~clk;

    ofdm_tx_frm_sched #(
        .PRE_LEN(PRE_LEN), .SYM_LEN(SYM_LEN), .GAP_LEN(GAP_LEN), .NSYM_W(NSYM_W)
    ) dut (
        .CLK_I(clk), .RST_I(rst_n), .START_I(start), .NSYM_I(nsym),
        .PRE_DAT_I(pre_dat), .PRE_WE_I(pre_we), .PRE_STB_I(pre_stb),
        .PRE_CYC_I(pre_cyc), .PRE_ACK_O(pre_ack),
        .SYM_DAT_I(sym_dat), .SYM_WE_I(sym_we), .SYM_STB_I(sym_stb),
        .SYM_CYC_I(sym_cyc), .SYM_ACK_O(sym_ack),
        .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o), .ACK_I(ack_i),
        .BUSY_O(busy), .FRM_DONE_O(frm_done)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          frm      = 0;
    int          pre_idx  = 0;
    int          sym_idx  = 0;
    int          cur_nsym = 0;
    bit          in_frame = 1'b0;

    logic        s_cyc, s_stb, s_we, s_busy, s_frm_done, s_pre_ack, s_sym_ack;
    logic [31:0] s_dat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pre_val(input int f, input int k);
        return 32'hA000_0000 | (32'(f & 255) << 16) | 32'(k & 65535);
    endfunction

    function automatic logic [31:0] sym_val(input int f, input int k);
        return 32'h5000_0000 | (32'(f & 255) << 16) | 32'(k & 65535);
    endfunction

    // Monitor: compare every output transfer against the scoreboard and check hold-on-stall
    logic [31:0] prev_dat   = 32'h0;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_hold_stb", 32'(stb_o), 32'd1);
                chk("stall_hold_dat", dat_o, prev_dat);
            end
            if (stb_o && we_o && cyc_o && ack_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_sample: got %0h, expected no sample (t=%0t)", dat_o, $time);
                end else begin
                    chk("sample", dat_o, exp_q.pop_front());
                end
            end
            prev_stall = stb_o && !ack_i;
            prev_dat   = dat_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // One clock: sample at negedge, advance the source models after the edge
    task automatic tick();
        bit px, sx;
        @(negedge clk);
        px = pre_ack && pre_we && pre_stb && pre_cyc;
        sx = sym_ack && sym_we && sym_stb && sym_cyc;
        s_cyc = cyc_o; s_stb = stb_o; s_we = we_o; s_busy = busy;
        s_frm_done = frm_done; s_pre_ack = pre_ack; s_sym_ack = sym_ack; s_dat = dat_o;
        if (in_frame && rst_n) begin
            if (pre_idx < PRE_LEN) chk("sym_ack_during_pre", 32'(s_sym_ack), 32'd0);
            else chk("pre_ack_after_pre", 32'(s_pre_ack), 32'd0);
            if (sym_idx >= cur_nsym * SYM_LEN) chk("sym_ack_after_last", 32'(s_sym_ack), 32'd0);
        end
        @(posedge clk);
        #1;
        if (px) pre_idx++;
        if (sx) sym_idx++;
        pre_dat = pre_val(frm, pre_idx);
        sym_dat = sym_val(frm, sym_idx);
    endtask

    // Reference model: a frame is PRE_LEN preamble samples then ns*SYM_LEN data samples
    task automatic begin_frame(input int ns);
        frm++;
        pre_idx  = 0;
        sym_idx  = 0;
        cur_nsym = ns;
        pre_dat  = pre_val(frm, 0);
        sym_dat  = sym_val(frm, 0);
        for (int k = 0; k < PRE_LEN; k++) exp_q.push_back(pre_val(frm, k));
        for (int k = 0; k < ns * SYM_LEN; k++) exp_q.push_back(sym_val(frm, k));
        start    = 1'b1;
        nsym     = ns[NSYM_W-1:0];
        in_frame = 1'b1;
        tick();
        start = 1'b0;
        nsym  = NSYM_W'($urandom_range(0, 255));
    endtask

    // mode 0 full rate, 1 backpressure burst, 2 data starvation, 3 random, 4 START re-pulse
    task automatic run_frame(input int ns, input int mode);
        int cyc_hi = 0, gap_cyc = 0, dones = 0, budget = 0, bp_step = 0, starve_left = 0;
        bit seen_cyc = 1'b0, done = 1'b0, starved = 1'b0, repulsed = 1'b0;
        bit bp_pat [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        begin_frame(ns);
        while (!done && budget < 20000) begin
            tick();
            budget++;
            if (s_cyc) begin
                cyc_hi++;
                seen_cyc = 1'b1;
            end else if (seen_cyc && s_busy) begin
                gap_cyc++;
            end
            if (s_frm_done) begin
                dones++;
                done = 1'b1;
                chk("done_busy_low", 32'(s_busy), 32'd0);
            end
            case (mode)
                1: begin
                    if (bp_step == 0 && pre_idx >= 150) bp_step = 1;
                    if (bp_step >= 1 && bp_step <= 11) begin
                        ack_i = bp_pat[bp_step-1];
                        bp_step++;
                    end else begin
                        ack_i = 1'b1;
                    end
                end
                2: begin
                    if (!starved && sym_idx == 38) begin
                        starved     = 1'b1;
                        starve_left = 5;
                        sym_stb     = 1'b0;
                    end else if (starve_left > 0) begin
                        chk("starve_cyc_high", 32'(s_cyc), 32'd1);
                        starve_left--;
                        if (starve_left == 0) begin
                            chk("starve_stb_low", 32'(s_stb), 32'd0);
                            sym_stb = 1'b1;
                        end
                    end
                end
                3: begin
                    ack_i   = ($urandom_range(0, 3) != 0);
                    pre_stb = ($urandom_range(0, 4) != 0);
                    sym_stb = ($urandom_range(0, 4) != 0);
                end
                4: begin
                    if (!repulsed && sym_idx == 100) begin
                        start    = 1'b1;
                        nsym     = 8'd5;
                        repulsed = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                end
                default: ack_i = 1'b1;
            endcase
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: got no FRM_DONE_O, expected pulse within 20000 cycles");
        end
        in_frame = 1'b0;
        start = 1'b0; ack_i = 1'b1; pre_stb = 1'b1; sym_stb = 1'b1;
        repeat (3) begin
            tick();
            if (s_frm_done) dones++;
        end
        chk("frm_done_pulses", 32'(dones), 32'd1);
        chk("busy_after_frame", 32'(s_busy), 32'd0);
        chk("gap_cycles", 32'(gap_cyc), 32'(GAP_LEN));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (mode == 0) chk("cyc_high_cycles", 32'(cyc_hi), 32'(PRE_LEN + ns * SYM_LEN + 1));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dat"}, s_dat, 32'h0);
        chk({tag, "_stb"}, 32'(s_stb), 32'd0);
        chk({tag, "_we"}, 32'(s_we), 32'd0);
        chk({tag, "_cyc"}, 32'(s_cyc), 32'd0);
        chk({tag, "_pre_ack"}, 32'(s_pre_ack), 32'd0);
        chk({tag, "_sym_ack"}, 32'(s_sym_ack), 32'd0);
        chk({tag, "_busy"}, 32'(s_busy), 32'd0);
        chk({tag, "_frm_done"}, 32'(s_frm_done), 32'd0);
    endtask

    // Reset asserted for one cycle at preamble sample 100, then a clean frame
    task automatic run_reset();
        int budget = 0;
        begin_frame(2);
        while (pre_idx < 100 && budget < 2000) begin
            tick();
            budget++;
        end
        chk("reach_pre_100", 32'(pre_idx), 32'd100);
        rst_n    = 1'b0;
        in_frame = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("midframe_reset");
        run_frame(2, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; nsym = '0; ack_i = 1'b1;
        pre_we = 1'b1; pre_stb = 1'b1; pre_cyc = 1'b1; pre_dat = 32'h0;
        sym_we = 1'b1; sym_stb = 1'b1; sym_cyc = 1'b1; sym_dat = 32'h0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        run_frame(2, 0);
        run_frame(2, 1);
        run_frame(2, 2);
        run_frame(0, 0);
        run_frame(2, 4);
        run_frame(3, 3);
        run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_tx_frm_sched.md
Name: ofdm_tx_frm_sched

Overview:
Frame scheduler at the output of the OFDM TX chain. It shares one Wishbone-style output port between two sources: a preamble sample source and the data-symbol stream from the IFFT/CP stage. For each frame it sequences preamble, then NSYM data symbols, then an idle guard gap. It owns both source ACKs and the frame-level CYC_O envelope.

Parameters:
PRE_LEN, 320, preamble samples per frame (must be >= 1).
SYM_LEN, 80, samples per data symbol, including the cyclic prefix (must be >= 1).
GAP_LEN, 16, idle cycles after the frame drains (0 is allowed).
NSYM_W, 8, width of the symbol-count input.

Ports:
CLK_I  in  1  clock; all logic on the rising edge.
RST_I  in  1  reset; synchronous, active-low (0 = reset).
START_I  in  1  frame request; sampled only in IDLE.
NSYM_I  in  NSYM_W  data symbols per frame; latched when START_I is accepted.
PRE_DAT_I  in  32  preamble sample, {Im[31:16], Re[15:0]}.
PRE_WE_I / PRE_STB_I / PRE_CYC_I  in  1 each  preamble source strobes.
PRE_ACK_O  out  1  preamble source acknowledge.
SYM_DAT_I  in  32  data sample, {Im, Re}.
SYM_WE_I / SYM_STB_I / SYM_CYC_I  in  1 each  data source strobes.
SYM_ACK_O  out  1  data source acknowledge.
DAT_O  out  32  output sample.
WE_O / STB_O / CYC_O  out  1 each  output strobes.
ACK_I  in  1  sink acknowledge.
BUSY_O  out  1  high in every state except IDLE.
FRM_DONE_O  out  1  one-cycle pulse on the GAP->IDLE transition.

Behaviour:
- Reset (RST_I=0 at a clock edge):
  - State=IDLE; all counters=0.
  - DAT_O=0; WE_O, STB_O, CYC_O, PRE_ACK_O, SYM_ACK_O, BUSY_O, FRM_DONE_O = 0.
  - Reset mid-frame aborts immediately; the in-flight output sample is discarded.
- Transfer definitions:
  - Input transfer: WE&STB&CYC&ACK all high at a clock edge.
  - Output transfer: WE_O&STB_O&CYC_O&ACK_I all high at a clock edge.
- Output stage: one registered entry (DAT_O, STB_O=WE_O=valid).
  - can_load = ~STB_O | ACK_I.
  - On load: DAT_O <= selected DAT_I; STB_O/WE_O <= 1. Latency from input transfer to DAT_O valid is 1 cycle.
  - On output transfer with no load: STB_O/WE_O <= 0.
  - Full throughput is 1 sample/cycle while ACK_I=1.
- Source ACKs are combinational:
  - Selected source: ACK = WE&STB&CYC & can_load & ~last_done.
  - Non-selected source ACK = 0 always.
  - In IDLE and GAP both ACKs are 0.
- last_done: set once the final sample of the current phase is accepted; clears on phase change.
- State machine:
  - IDLE: if START_I=1, latch NSYM_I, go to PRE; BUSY_O=1 from the next cycle.
  - PRE: select the preamble source. Count preamble transfers 0..PRE_LEN-1. On the PRE_LEN-th transfer, go to SYM, or to DRAIN if the latched NSYM=0.
  - SYM: select the data source.
    - Sample counter wraps SYM_LEN-1 -> 0; the symbol counter increments on each wrap.
    - After NSYM*SYM_LEN transfers, go to DRAIN.
  - DRAIN: no input accepted; wait until STB_O=0 (last sample taken by the sink), then go to GAP with the gap counter cleared.
  - GAP: CYC_O=0; count GAP_LEN cycles, then pulse FRM_DONE_O and go to IDLE. GAP_LEN=0 goes to IDLE on the first GAP cycle, still with the pulse.
- CYC_O:
  - Rises together with the first STB_O of the frame.
  - Stays high through PRE, SYM and DRAIN, including stall cycles with STB_O=0 (source starvation or backpressure).
  - Falls on entry to GAP.
- Source starvation: STB low leaves state and counters frozen and produces no output bubble errors.
- Simultaneous output transfer and new load in the same cycle: the stage stays valid with the new data.
- START_I outside IDLE is ignored; there is no queuing.
- NSYM_I changes after START_I has been accepted have no effect on the current frame.
- Counter widths: sample counter ceil(log2(max(PRE_LEN,SYM_LEN)+1)) bits; symbol counter NSYM_W bits. No overflow for legal parameters.

Test Plan:
- Basic frame: PRE_LEN=320, SYM_LEN=80, NSYM_I=2, both sources always valid, ACK_I=1, START_I pulse.
  - Exactly 320 preamble then 160 data samples appear on DAT_O, in order.
  - CYC_O is high for 480 transfers plus 1 pipeline cycle.
  - 16 cycles later FRM_DONE_O pulses once.
- Backpressure: ACK_I toggles 1,0,1,0 and then holds 0 for 7 cycles mid-preamble.
  - DAT_O is held stable while unacked; no sample is lost or duplicated.
  - SYM_ACK_O stays 0 throughout PRE.
- Starvation: the data source drops STB for 5 cycles after data sample 37.
  - CYC_O stays 1; STB_O goes 0 after the held sample drains.
  - The sequence resumes at sample 38; total data count is still NSYM*80.
- NSYM_I=0: frame carries 320 preamble samples only, then GAP and FRM_DONE_O; SYM_ACK_O never asserts.
- START_I re-pulsed during SYM, with NSYM_I changed to 5 at the same time: the frame still carries 2 symbols, and no second frame starts.
- Reset mid-frame: drive RST_I=0 for 1 cycle at preamble sample 100.
  - All outputs are 0 the next cycle; state is IDLE.
  - A new START_I then produces a complete frame starting at preamble sample 0.
